booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Round-robin arbiter and sequencer that shares one `booth_multiplier` instance between N requesters. Captures a granted requester's operands, drives the multiplier's start/ready handshake, and returns the signed product tagged with the requester index. Sits between requesting datapath units and the single multiplier core; the multiplier's `clk`/`rst` are driven from the same nets.

## Interface
- `N`, 4: number of requesters (2..8).
- `WIDTH`, 8: operand width; product is 2*WIDTH.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with `BOOTH_ARB_TIMEOUT_EN`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N  per-requester request level.
- `m_in`  in  N*WIDTH  multiplicands; requester i occupies bits [i*WIDTH +: WIDTH].
- `r_in`  in  N*WIDTH  multipliers; same packing.
- `gnt`  out  N  one-hot, one-cycle pulse; operands of that requester have been captured.
- `mul_start`  out  1  start to multiplier.
- `mul_m`, `mul_r`  out  WIDTH each  registered operands to multiplier.
- `mul_ready`  in  1  multiplier ready level.
- `mul_ans`  in  2*WIDTH  multiplier product.
- `res_valid`  out  1  one-cycle result strobe.
- `res_id`  out  clog2(N)  index of requester the result belongs to.
- `res_data`  out  2*WIDTH  signed product.
- `res_err`  out  1  result aborted by watchdog (valid with `res_valid`).

## Operation
- States: IDLE, BUSY, RUN, DONE. Round-robin pointer `ptr` (clog2(N) bits).
- IDLE: if `req` nonzero, select first set bit scanning ptr, ptr+1, ... wrapping modulo N. On that edge: latch `m_in`/`r_in` slice into `mul_m`/`mul_r`, record index, set `gnt[idx]`=1, `mul_start`=1, go BUSY. No req: stay.
- BUSY: `mul_start` held 1; `gnt` back to 0. When `mul_ready`==0 (multiplier accepted), drop `mul_start`, go RUN.
- RUN: `mul_start`=0. When `mul_ready`==1, latch `mul_ans` into `res_data`, `res_id`=index, `res_valid`=1, `res_err`=0, go DONE.
- DONE: `res_valid` returns to 0; `res_data`/`res_id` hold until next result; ptr = (index+1) mod N; go IDLE.
- Requester protocol: hold `req` and operands stable until `gnt`; may change operands the cycle after `gnt`. `req` still high after `gnt` is a new request.
- Requester served in DONE and still requesting competes next IDLE at lowest priority.
- Requests and operands of non-granted requesters are ignored while not in IDLE.
- `res_data` is the multiplier output verbatim (two's-complement, 2*WIDTH); arbiter performs no arithmetic.

## Timing
- Reset values (registered, applied at the rising edge with `rst`=1): state IDLE, ptr 0, `gnt` 0, `mul_start` 0, `mul_m`/`mul_r` 0, `res_valid` 0, `res_id` 0, `res_data` 0, `res_err` 0, watchdog counter 0.
- `rst` mid-operation: all of the above apply at that edge; in-flight operation discarded, no `res_valid`.
- Cycle 0 req sampled in IDLE; cycle 1 `gnt` and `mul_start` high; `mul_start` stays high ≥1 cycle, until `mul_ready` low sampled.
- `res_valid` asserts the cycle after `mul_ready` high is sampled in RUN. Earliest next `gnt` is 2 cycles after `res_valid`.
- Overhead beyond multiplier latency: 3 cycles per operation (grant, ready-low detect, DONE).
- At most one operation outstanding; `gnt` and `res_valid` never high in the same cycle.

## Configuration
- `BOOTH_ARB_TIMEOUT_EN` defined: counter clears on entering BUSY, increments each cycle in BUSY/RUN; on reaching `TIMEOUT` go DONE with `res_valid`=1, `res_err`=1, `res_data`=0, `mul_start`=0; ptr advances normally.
- Not defined: no counter; BUSY/RUN wait indefinitely; `res_err` tied 0.

## Test plan
- Single req: req[0], m=33, r=20 -> one `gnt[0]` pulse, `res_valid` with `res_id`=0, `res_data`=660 (0x0294), `res_err`=0.
- Signed: req[2], m=-5 (0xFB), r=7 -> `res_data`=0xFFDD, `res_id`=2.
- Contention: req[1] and req[3] asserted same cycle after reset -> grant order 1 then 3; each gets its own product.
- Fairness: all four held high for 8 operations -> grant order 0,1,2,3,0,1,2,3; no requester granted twice consecutively.
- Reset during RUN: assert `rst` one cycle -> next cycle all outputs at reset values, no `res_valid`; new req[0] then served normally with ptr starting at 0.
- Watchdog (macro defined, TIMEOUT=64): model holds `mul_ready` high after start -> `res_valid` with `res_err`=1, `res_data`=0 exactly 64 cycles after entering BUSY; next request still granted.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one booth_multiplier among N requesters.
// Optional watchdog abort enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mult_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req,
    input  logic [N*WIDTH-1:0]        m_in,
    input  logic [N*WIDTH-1:0]        r_in,
    output logic [N-1:0]              gnt,
    output logic                      mul_start,
    output logic [WIDTH-1:0]          mul_m,
    output logic [WIDTH-1:0]          mul_r,
    input  logic                      mul_ready,
    input  logic [2*WIDTH-1:0]        mul_ans,
    output logic                      res_valid,
    output logic [$clog2(N)-1:0]      res_id,
    output logic [2*WIDTH-1:0]        res_data,
    output logic                      res_err
);
    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     idx_q, idx_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic               mul_start_q, mul_start_d;
    logic [WIDTH-1:0]   mul_m_q, mul_m_d;
    logic [WIDTH-1:0]   mul_r_q, mul_r_d;
    logic               res_valid_q, res_valid_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic [2*WIDTH-1:0] res_data_q, res_data_d;
    logic               res_err_q, res_err_d;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    // cand[k] is the requester examined k-th when scanning from ptr
    logic [IDW-1:0] cand [N];
    logic           sel_found;
    logic [IDW-1:0] sel_idx;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = IDW'((32'(ptr_q) + 32'(gi)) % 32'(N));
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        gnt_d       = '0;
        mul_start_d = mul_start_q;
        mul_m_d     = mul_m_q;
        mul_r_d     = mul_r_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    mul_m_d     = m_in[sel_idx*WIDTH +: WIDTH];
                    mul_r_d     = r_in[sel_idx*WIDTH +: WIDTH];
                    idx_d       = sel_idx;
                    gnt_d       = N'(1) << sel_idx;
                    mul_start_d = 1'b1;
                    state_d     = BUSY;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            BUSY: begin
                // ready dropping is the multiplier's acknowledgement of start
                if (!mul_ready) begin
                    mul_start_d = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (mul_ready) begin
                    res_data_d  = mul_ans;
                    res_id_d    = idx_q;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                    state_d     = DONE;
                end
            end
            default: begin
                ptr_d   = (idx_q == IDW'(N - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
        endcase
`ifdef BOOTH_ARB_TIMEOUT_EN
        // a genuine completion on the same cycle wins over the abort
        if (state_q == BUSY || state_q == RUN) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(TIMEOUT) && state_d != DONE) begin
                res_data_d  = '0;
                res_id_d    = idx_q;
                res_valid_d = 1'b1;
                res_err_d   = 1'b1;
                mul_start_d = 1'b0;
                state_d     = DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            gnt_q       <= '0;
            mul_start_q <= 1'b0;
            mul_m_q     <= '0;
            mul_r_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            mul_start_q <= mul_start_d;
            mul_m_q     <= mul_m_d;
            mul_r_q     <= mul_r_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign mul_start = mul_start_q;
    assign mul_m     = mul_m_q;
    assign mul_r     = mul_r_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    assign res_err   = res_err_q;
`else
    assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural multiplier model.
// Define BOOTH_ARB_TIMEOUT_EN for both files to exercise the watchdog abort.
module tb_booth_mult_arbiter;
    localparam int L = 5;   // cycles the model holds mul_ready low

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] m_in, r_in;
    logic [3:0]  gnt;
    logic        mul_start;
    logic [7:0]  mul_m, mul_r;
    logic        mul_ready;
    logic [15:0] mul_ans;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_data;
    logic        res_err;

    int compared   = 0;
    int mismatched = 0;

    booth_mult_arbiter #(.N(4), .WIDTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .m_in(m_in), .r_in(r_in),
        .gnt(gnt), .mul_start(mul_start), .mul_m(mul_m), .mul_r(mul_r),
        .mul_ready(mul_ready), .mul_ans(mul_ans),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Multiplier model: accepts start while ready, busy for L cycles.
    logic              stuck;
    logic              mdl_busy;
    int                mdl_cnt;
    logic signed [7:0] cap_m, cap_r;

    always @(posedge clk) begin
        if (rst) begin
            mul_ready <= 1'b1;
            mul_ans   <= '0;
            mdl_busy  <= 1'b0;
            mdl_cnt   <= 0;
            cap_m     <= '0;
            cap_r     <= '0;
        end else if (!mdl_busy && mul_ready && mul_start && !stuck) begin
            cap_m     <= mul_m;
            cap_r     <= mul_r;
            mul_ready <= 1'b0;
            mdl_busy  <= 1'b1;
            mdl_cnt   <= L - 1;
        end else if (mdl_busy) begin
            if (mdl_cnt == 0) begin
                mul_ans   <= cap_m * cap_r;
                mul_ready <= 1'b1;
                mdl_busy  <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] m, input logic [7:0] r);
        m_in[i*8 +: 8] = m;
        r_in[i*8 +: 8] = r;
    endtask

    task automatic wait_gnt(input logic [3:0] exp_gnt, input logic [7:0] exp_m,
                            input logic [7:0] exp_r, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0 && n < 100);
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, ".mul_start"}, 32'(mul_start), 32'd1);
        chk({tag, ".mul_m"}, 32'(mul_m), 32'(exp_m));
        chk({tag, ".mul_r"}, 32'(mul_r), 32'(exp_r));
        chk({tag, ".no_res_with_gnt"}, 32'(res_valid), 32'd0);
    endtask

    task automatic wait_res(input logic [1:0] exp_id, input logic [15:0] exp_data,
                            input logic exp_err, input int exp_lat, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 200);
        $display("txn %s: id=%0d data=0x%04h err=%0b after %0d cycles",
                 tag, res_id, res_data, res_err, n);
        chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, ".res_id"}, 32'(res_id), 32'(exp_id));
        chk({tag, ".res_data"}, 32'(res_data), 32'(exp_data));
        chk({tag, ".res_err"}, 32'(res_err), 32'(exp_err));
        if (exp_lat >= 0) chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        @(negedge clk);
        chk({tag, ".res_valid_pulse"}, 32'(res_valid), 32'd0);
        chk({tag, ".res_data_hold"}, 32'(res_data), 32'(exp_data));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".mul_start"}, 32'(mul_start), 32'd0);
        chk({tag, ".mul_m"}, 32'(mul_m), 32'd0);
        chk({tag, ".mul_r"}, 32'(mul_r), 32'd0);
        chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, ".res_id"}, 32'(res_id), 32'd0);
        chk({tag, ".res_data"}, 32'(res_data), 32'd0);
        chk({tag, ".res_err"}, 32'(res_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [15:0] fair_prod [4];
        int pulses;
        fair_prod = '{16'h000A, 16'h0028, 16'h005A, 16'h00A0};
        rst   = 1'b1;
        req   = 4'b0;
        m_in  = '0;
        r_in  = '0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // Single request: 33 * 20 = 660
        set_op(0, 8'd33, 8'd20);
        req = 4'b0001;
        wait_gnt(4'b0001, 8'd33, 8'd20, "single");
        req = 4'b0000;
        wait_res(2'd0, 16'h0294, 1'b0, L + 2, "single");

        // Signed: -5 * 7 = -35
        set_op(2, 8'hFB, 8'd7);
        req = 4'b0100;
        wait_gnt(4'b0100, 8'hFB, 8'd7, "signed");
        req = 4'b0000;
        wait_res(2'd2, 16'hFFDD, 1'b0, L + 2, "signed");

        // Contention after reset: 1 before 3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_op(1, 8'd12, 8'hFD);
        set_op(3, 8'h80, 8'h80);
        req = 4'b1010;
        wait_gnt(4'b0010, 8'd12, 8'hFD, "contend1");
        req = 4'b1000;
        wait_res(2'd1, 16'hFFDC, 1'b0, L + 2, "contend1");
        wait_gnt(4'b1000, 8'h80, 8'h80, "contend3");
        req = 4'b0000;
        wait_res(2'd3, 16'h4000, 1'b0, L + 2, "contend3");

        // Fairness: all four held for eight operations
        for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'(10 * (i + 1)));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_gnt(4'(1 << (k % 4)), 8'(k % 4 + 1), 8'(10 * (k % 4 + 1)), "fair");
            wait_res(2'(k % 4), fair_prod[k % 4], 1'b0, L + 2, "fair");
        end
        req = 4'b0000;

        // Move ptr to 2, then reset during RUN of requester 2
        set_op(1, 8'd7, 8'd8);
        req = 4'b0010;
        wait_gnt(4'b0010, 8'd7, 8'd8, "pre_rst");
        req = 4'b0000;
        wait_res(2'd1, 16'h0038, 1'b0, L + 2, "pre_rst");
        set_op(2, 8'd50, 8'd3);
        req = 4'b0100;
        wait_gnt(4'b0100, 8'd50, 8'd3, "in_run");
        req = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("mid_rst");
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        chk("mid_rst.no_result", 32'(pulses), 32'd0);

        // ptr restarted at 0: requester 0 beats requester 3
        set_op(0, 8'hFF, 8'hFF);
        set_op(3, 8'd100, 8'hFE);
        req = 4'b1001;
        wait_gnt(4'b0001, 8'hFF, 8'hFF, "post_rst0");
        req = 4'b1000;
        wait_res(2'd0, 16'h0001, 1'b0, L + 2, "post_rst0");
        wait_gnt(4'b1000, 8'd100, 8'hFE, "post_rst3");
        req = 4'b0000;
        wait_res(2'd3, 16'hFF38, 1'b0, L + 2, "post_rst3");

`ifdef BOOTH_ARB_TIMEOUT_EN
        // Watchdog: multiplier never accepts start
        stuck = 1'b1;
        set_op(1, 8'd5, 8'd5);
        req = 4'b0010;
        wait_gnt(4'b0010, 8'd5, 8'd5, "wdog");
        req = 4'b0000;
        wait_res(2'd1, 16'h0000, 1'b1, 64, "wdog");
        chk("wdog.start_dropped", 32'(mul_start), 32'd0);
        stuck = 1'b0;
        set_op(2, 8'd6, 8'd7);
        req = 4'b0100;
        wait_gnt(4'b0100, 8'd6, 8'd7, "after_wdog");
        req = 4'b0000;
        wait_res(2'd2, 16'h002A, 1'b0, L + 2, "after_wdog");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
